// File: rtl/cb_seg_ctrl_param.sv
// Code-block segmentation controller: reads one transport-block descriptor per job and
// streams C- blocks of K- bits then C+ blocks of K+ bits, with filler and per-block CRC.
module cb_seg_ctrl_param #(
   parameter int CNT_W      = 16,
   parameter int NBLK_W     = 4,
   parameter int CRC_LEN    = 24,
   parameter int GAP_CYCLES = 6,
   parameter int DESC_W     = 3*CNT_W + 2*NBLK_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              desc_empty,
   input  logic [DESC_W-1:0] desc_data,
   output logic              desc_rd,
   input  logic              data_empty,
   output logic              data_rd,
   input  logic              out_full,
   output logic              wreq,
   output logic              mux_fill,
   output logic              mux_crc,
   output logic              crc_init,
   output logic              crc_en,
   output logic              crc_nshift,
   output logic              start,
   output logic              filling,
   output logic              crc_phase,
   output logic [CNT_W-1:0]  block_len,
   output logic              last_block,
   output logic              desc_err,
   output logic              busy
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CRC_L    = CNT_W'(CRC_LEN);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [NBLK_W-1:0] BLK_ONE  = NBLK_W'(1);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

   typedef enum logic [2:0] {
      IDLE, DESC_RD, DESC_LATCH, BLK_LOAD, STREAM, GAP
   } state_t;

   state_t state_reg, state_next;

   logic [CNT_W-1:0]  kp_reg, km_reg, f_reg, leff_reg;
   logic [CNT_W-1:0]  rem_reg, fill_reg, len_reg;
   logic [NBLK_W-1:0] cp_reg, cm_reg;
   logic              first_reg, last_reg;
   logic [GAP_W-1:0]  gap_reg;

   // Descriptor fields as presented by the FIFO, {K+, K-, C+, C-, F}
   logic [CNT_W-1:0]  d_kp, d_km, d_f, d_leff, d_k1;
   logic [NBLK_W-1:0] d_cp, d_cm;
   logic [NBLK_W:0]   d_c;
   logic [CNT_W:0]    d_need;
   logic              d_reject;

   assign {d_kp, d_km, d_cp, d_cm, d_f} = desc_data;
   assign d_c      = {1'b0, d_cp} + {1'b0, d_cm};
   assign d_leff   = (d_c > (NBLK_W+1)'(1)) ? CRC_L : '0;
   assign d_k1     = (d_cm != '0) ? d_km : d_kp;
   assign d_need   = {1'b0, d_f} + {1'b0, d_leff};
   assign d_reject = (d_c == '0) || ({1'b0, d_k1} <= d_need);

   // Next block selection: all K- blocks are issued before any K+ block
   logic              use_m;
   logic [CNT_W-1:0]  k_sel;
   logic [NBLK_W-1:0] cm_dec, cp_dec;
   logic              last_sel;

   assign use_m    = (cm_reg != '0);
   assign k_sel    = use_m ? km_reg : kp_reg;
   assign cm_dec   = use_m ? (cm_reg - BLK_ONE) : cm_reg;
   assign cp_dec   = use_m ? cp_reg : (cp_reg - BLK_ONE);
   assign last_sel = (cm_dec == '0) && (cp_dec == '0);

   // Classification of the pending bit; it holds while the stream is stalled
   logic is_fill, is_data, advance, in_stream;

   assign in_stream = (state_reg == STREAM);
   assign is_fill   = (fill_reg != '0);
   assign is_data   = !is_fill && (rem_reg > leff_reg);
   assign advance   = in_stream && !out_full && !(is_data && data_empty);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         kp_reg    <= '0;
         km_reg    <= '0;
         f_reg     <= '0;
         leff_reg  <= '0;
         cp_reg    <= '0;
         cm_reg    <= '0;
         rem_reg   <= '0;
         fill_reg  <= '0;
         len_reg   <= '0;
         first_reg <= 1'b0;
         last_reg  <= 1'b0;
         gap_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            DESC_LATCH: begin
               kp_reg    <= d_kp;
               km_reg    <= d_km;
               cp_reg    <= d_cp;
               cm_reg    <= d_cm;
               f_reg     <= d_f;
               leff_reg  <= d_leff;
               first_reg <= 1'b1;
            end
            BLK_LOAD: begin
               rem_reg   <= k_sel;
               fill_reg  <= first_reg ? f_reg : '0;
               first_reg <= 1'b0;
               cm_reg    <= cm_dec;
               cp_reg    <= cp_dec;
               len_reg   <= k_sel;
               last_reg  <= last_sel;
            end
            STREAM: begin
               if (advance) begin
                  rem_reg <= rem_reg - CNT_ONE;
                  if (is_fill) begin
                     fill_reg <= fill_reg - CNT_ONE;
                  end
                  if (rem_reg == CNT_ONE) begin
                     gap_reg <= GAP_LAST;
                  end
               end
            end
            GAP: begin
               gap_reg <= gap_reg - GAP_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      desc_rd    = 1'b0;
      data_rd    = 1'b0;
      wreq       = 1'b0;
      mux_fill   = 1'b1;
      mux_crc    = 1'b0;
      crc_init   = 1'b0;
      crc_en     = 1'b0;
      crc_nshift = 1'b1;
      start      = 1'b0;
      filling    = 1'b0;
      crc_phase  = 1'b0;
      desc_err   = 1'b0;
      busy       = (state_reg != IDLE);
      block_len  = len_reg;
      last_block = last_reg;

      case (state_reg)
         IDLE: begin
            if (!desc_empty) begin
               state_next = DESC_RD;
            end
         end
         DESC_RD: begin
            desc_rd    = 1'b1;
            state_next = DESC_LATCH;
         end
         DESC_LATCH: begin
            if (d_reject) begin
               desc_err   = 1'b1;
               state_next = IDLE;
            end else begin
               state_next = BLK_LOAD;
            end
         end
         BLK_LOAD: begin
            start      = 1'b1;
            crc_init   = 1'b1;
            crc_en     = 1'b1;
            block_len  = k_sel;
            last_block = last_sel;
            state_next = STREAM;
         end
         STREAM: begin
            if (is_fill) begin
               mux_fill = 1'b0;
               filling  = 1'b1;
            end else if (is_data) begin
               data_rd  = advance;
            end else begin
               mux_crc    = 1'b1;
               crc_phase  = 1'b1;
               crc_nshift = 1'b0;
            end
            wreq   = advance;
            crc_en = advance;
            if (advance && (rem_reg == CNT_ONE)) begin
               state_next = GAP;
            end
         end
         GAP: begin
            if (gap_reg == '0) begin
               state_next = ((cm_reg != '0) || (cp_reg != '0)) ? BLK_LOAD : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cb_seg_ctrl_param.sv
// Self-checking bench for cb_seg_ctrl_param: a job-level model expands each descriptor
// into the expected bit-type sequence, which is compared with the observed wreq stream.
module tb_cb_seg_ctrl_param;

   localparam int CNT_W      = 16;
   localparam int NBLK_W     = 4;
   localparam int CRC_LEN    = 24;
   localparam int GAP_CYCLES = 6;
   localparam int DESC_W     = 3*CNT_W + 2*NBLK_W;

   logic              clk = 1'b0;
   logic              reset, desc_empty, data_empty, out_full;
   logic [DESC_W-1:0] desc_data;
   logic              desc_rd, data_rd, wreq, mux_fill, mux_crc, crc_init, crc_en;
   logic              crc_nshift, start, filling, crc_phase, last_block, desc_err, busy;
   logic [CNT_W-1:0]  block_len;

   cb_seg_ctrl_param #(
      .CNT_W(CNT_W), .NBLK_W(NBLK_W), .CRC_LEN(CRC_LEN), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .desc_empty(desc_empty), .desc_data(desc_data),
      .desc_rd(desc_rd), .data_empty(data_empty), .data_rd(data_rd), .out_full(out_full),
      .wreq(wreq), .mux_fill(mux_fill), .mux_crc(mux_crc), .crc_init(crc_init),
      .crc_en(crc_en), .crc_nshift(crc_nshift), .start(start), .filling(filling),
      .crc_phase(crc_phase), .block_len(block_len), .last_block(last_block),
      .desc_err(desc_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;

   // Observation (sampled on the falling edge)
   int obs_q[$];
   int start_cyc[$];
   int start_len[$];
   int start_last[$];
   int n_wreq, n_rd, n_err, n_bad_rd, n_stray, n_start_bad;
   int first_wreq_cyc, last_wreq_cyc, desc_rd_cyc, idle_cyc, fall_cyc;
   bit busy_d = 1'b0;

   always @(negedge clk) begin
      int code;
      if (wreq) begin
         code = 3;
         if (crc_en && filling && !mux_fill && !mux_crc && !crc_phase && !data_rd)
            code = 0;
         else if (crc_en && data_rd && mux_fill && !mux_crc && crc_nshift && !filling && !crc_phase)
            code = 1;
         else if (crc_en && crc_phase && mux_crc && !crc_nshift && mux_fill && !filling && !data_rd)
            code = 2;
         obs_q.push_back(code);
         if (n_wreq == 0) first_wreq_cyc = cyc;
         last_wreq_cyc = cyc;
         n_wreq++;
      end
      if (data_rd) begin
         n_rd++;
         if (!wreq) n_bad_rd++;
      end
      if (crc_en && !wreq && !start) n_stray++;
      if (start) begin
         start_cyc.push_back(cyc);
         start_len.push_back(int'(block_len));
         start_last.push_back(int'(last_block));
         if (!crc_init || !crc_en || wreq) n_start_bad++;
      end
      if (desc_err) n_err++;
      if (desc_rd) desc_rd_cyc = cyc;
      if (busy_d && !busy) idle_cyc = cyc;
      busy_d = busy;
   end

   // Job-level model
   int exp_q[$];
   int exp_len[$];
   int exp_last[$];
   int exp_rd, exp_err;

   task automatic model_job(input int kp, input int km, input int cp, input int cm, input int f);
      int c, leff, k1;
      c    = cp + cm;
      leff = (c > 1) ? CRC_LEN : 0;
      k1   = (cm > 0) ? km : kp;
      if (c == 0 || k1 <= f + leff) begin
         exp_err++;
         return;
      end
      for (int j = 0; j < c; j++) begin
         int k, fb;
         k  = (j < cm) ? km : kp;
         fb = (j == 0) ? f : 0;
         exp_len.push_back(k);
         exp_last.push_back((j == c - 1) ? 1 : 0);
         for (int b = 0; b < k; b++)
            exp_q.push_back((b < fb) ? 0 : ((b < k - leff) ? 1 : 2));
         exp_rd += k - fb - leff;
      end
   endtask

   function automatic int q_diff(input int a[$], input int b[$]);
      if (a.size() != b.size()) return -2;
      foreach (a[i]) if (a[i] != b[i]) return i;
      return -1;
   endfunction

   task automatic clear_all();
      obs_q.delete(); start_cyc.delete(); start_len.delete(); start_last.delete();
      exp_q.delete(); exp_len.delete(); exp_last.delete();
      n_wreq = 0; n_rd = 0; n_err = 0; n_bad_rd = 0; n_stray = 0; n_start_bad = 0;
      exp_rd = 0; exp_err = 0;
      first_wreq_cyc = -1; last_wreq_cyc = -1; desc_rd_cyc = -1; idle_cyc = -1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_desc(input int kp, input int km, input int cp, input int cm,
                            input int f, output bit ok);
      int n;
      desc_data  = {CNT_W'(kp), CNT_W'(km), NBLK_W'(cp), NBLK_W'(cm), CNT_W'(f)};
      desc_empty = 1'b0;
      fall_cyc   = cyc;
      n = 0;
      while (!desc_rd && n < 50) begin
         tick();
         n++;
      end
      ok = desc_rd;
      desc_empty = 1'b1;
   endtask

   task automatic wait_idle(input bit stall, output bit ok);
      int n;
      n = 0;
      while (busy && n < 30000) begin
         if (stall) begin
            out_full   = ($urandom_range(0, 4) == 0);
            data_empty = ($urandom_range(0, 4) == 0);
         end
         tick();
         n++;
      end
      ok = !busy;
      out_full   = 1'b0;
      data_empty = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [13:0] vec;
      reset = 1'b1; desc_empty = 1'b1; data_empty = 1'b0; out_full = 1'b0; desc_data = '0;
      repeat (3) tick();
      vec = {wreq, busy, mux_fill, crc_nshift, data_rd, crc_en, start, desc_rd,
             mux_crc, filling, crc_phase, last_block, desc_err, crc_init};
      n_cmp++;
      if (vec !== 14'b00_11_0000_000000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want %b", vec, 14'b00_11_0000_000000);
      end
      n_cmp++;
      if (block_len !== '0) begin
         n_fail++;
         $display("FAIL reset_block_len: got %0d want 0", block_len);
      end
      reset = 1'b0;
      tick();
      $display("reset: outputs checked at reset values");
   endtask

   task automatic test_single_block();
      bit ok1, ok2;
      int d;
      clear_all();
      model_job(0, 40, 0, 1, 4);
      send_desc(0, 40, 0, 1, 4, ok1);
      wait_idle(1'b0, ok2);
      n_cmp++;
      if (!(ok1 && ok2)) begin n_fail++; $display("FAIL single_timeout: got ok=%0b%0b want 11", ok1, ok2); end
      d = q_diff(obs_q, exp_q);
      n_cmp++;
      if (d != -1) begin n_fail++; $display("FAIL single_bits: got %0d bits want %0d (diff idx %0d)", obs_q.size(), exp_q.size(), d); end
      n_cmp++;
      if (desc_rd_cyc - fall_cyc != 1) begin n_fail++; $display("FAIL single_desc_rd_lat: got %0d want 1", desc_rd_cyc - fall_cyc); end
      n_cmp++;
      if (start_cyc.size() != 1 || start_cyc[0] - desc_rd_cyc != 2) begin
         n_fail++; $display("FAIL single_start_lat: got %0d starts want 1 start 2 cycles after desc_rd", start_cyc.size());
      end
      n_cmp++;
      if (start_cyc.size() == 1 && first_wreq_cyc - start_cyc[0] != 1) begin
         n_fail++; $display("FAIL single_first_wreq: got %0d want 1", first_wreq_cyc - start_cyc[0]);
      end
      n_cmp++;
      if (idle_cyc - last_wreq_cyc != GAP_CYCLES + 1) begin
         n_fail++; $display("FAIL single_gap: got %0d want %0d", idle_cyc - last_wreq_cyc, GAP_CYCLES + 1);
      end
      n_cmp++;
      if (q_diff(start_len, exp_len) != -1 || q_diff(start_last, exp_last) != -1 || n_start_bad != 0) begin
         n_fail++; $display("FAIL single_start_info: got len %0d last %0d bad %0d want len 40 last 1 bad 0",
                            start_len.size() > 0 ? start_len[0] : -1, start_last.size() > 0 ? start_last[0] : -1, n_start_bad);
      end
      n_cmp++;
      if (n_rd != exp_rd || n_stray != 0) begin
         n_fail++; $display("FAIL single_reads: got %0d reads %0d stray want %0d reads 0 stray", n_rd, n_stray, exp_rd);
      end
      $display("single_block: %0d bits, %0d data reads", obs_q.size(), n_rd);
   endtask

   task automatic test_two_blocks_crc();
      bit ok1, ok2;
      int d;
      clear_all();
      model_job(6144, 0, 2, 0, 0);
      send_desc(6144, 0, 2, 0, 0, ok1);
      wait_idle(1'b0, ok2);
      n_cmp++;
      if (!(ok1 && ok2)) begin n_fail++; $display("FAIL two_timeout: got ok=%0b%0b want 11", ok1, ok2); end
      d = q_diff(obs_q, exp_q);
      n_cmp++;
      if (d != -1) begin n_fail++; $display("FAIL two_bits: got %0d bits want %0d (diff idx %0d)", obs_q.size(), exp_q.size(), d); end
      n_cmp++;
      if (start_cyc.size() != 2 || start_cyc[1] - start_cyc[0] != 6151) begin
         n_fail++; $display("FAIL two_start_spacing: got %0d starts spacing %0d want 2 starts spacing 6151",
                            start_cyc.size(), start_cyc.size() == 2 ? start_cyc[1] - start_cyc[0] : -1);
      end
      n_cmp++;
      if (n_rd != 12240) begin n_fail++; $display("FAIL two_reads: got %0d want 12240", n_rd); end
      $display("two_blocks_crc: %0d bits, %0d data reads", obs_q.size(), n_rd);
   endtask

   task automatic test_mixed();
      bit ok1, ok2;
      int d;
      clear_all();
      model_job(1088, 1056, 1, 1, 8);
      send_desc(1088, 1056, 1, 1, 8, ok1);
      wait_idle(1'b0, ok2);
      n_cmp++;
      if (!(ok1 && ok2)) begin n_fail++; $display("FAIL mixed_timeout: got ok=%0b%0b want 11", ok1, ok2); end
      d = q_diff(obs_q, exp_q);
      n_cmp++;
      if (d != -1) begin n_fail++; $display("FAIL mixed_bits: got %0d bits want %0d (diff idx %0d)", obs_q.size(), exp_q.size(), d); end
      n_cmp++;
      if (q_diff(start_len, exp_len) != -1 || q_diff(start_last, exp_last) != -1) begin
         n_fail++; $display("FAIL mixed_block_info: got %0d starts want %0d with K 1056,1088 last 0,1", start_len.size(), exp_len.size());
      end
      n_cmp++;
      if (start_cyc.size() != 2 || start_cyc[1] - start_cyc[0] != 1056 + GAP_CYCLES + 1) begin
         n_fail++; $display("FAIL mixed_spacing: got %0d starts want spacing %0d", start_cyc.size(), 1056 + GAP_CYCLES + 1);
      end
      n_cmp++;
      if (n_rd != exp_rd) begin n_fail++; $display("FAIL mixed_reads: got %0d want %0d", n_rd, exp_rd); end
      $display("mixed: %0d bits, %0d data reads", obs_q.size(), n_rd);
   endtask

   task automatic test_backpressure();
      bit ok1, ok2;
      int d, n, w0, r0;
      logic [3:0] hold_vec;
      clear_all();
      model_job(0, 200, 0, 1, 0);
      send_desc(0, 200, 0, 1, 0, ok1);
      n = 0;
      while (n_wreq < 20 && n < 100) begin tick(); n++; end
      w0 = n_wreq; r0 = n_rd;
      out_full = 1'b1;
      tick();
      hold_vec = {wreq, crc_en, mux_fill, crc_nshift};
      tick(); tick();
      out_full = 1'b0; data_empty = 1'b1;
      tick(); tick();
      data_empty = 1'b0;
      n_cmp++;
      if (hold_vec !== 4'b0011) begin n_fail++; $display("FAIL bp_hold_outputs: got %b want 0011", hold_vec); end
      n_cmp++;
      if (n_wreq != w0 || n_rd != r0) begin
         n_fail++; $display("FAIL bp_frozen: got %0d wreq %0d reads in stall window want 0 0", n_wreq - w0, n_rd - r0);
      end
      wait_idle(1'b0, ok2);
      n_cmp++;
      if (!(ok1 && ok2)) begin n_fail++; $display("FAIL bp_timeout: got ok=%0b%0b want 11", ok1, ok2); end
      d = q_diff(obs_q, exp_q);
      n_cmp++;
      if (d != -1) begin n_fail++; $display("FAIL bp_bits: got %0d bits want %0d (diff idx %0d)", obs_q.size(), exp_q.size(), d); end
      n_cmp++;
      if (start_cyc.size() != 1 || last_wreq_cyc - start_cyc[0] != 205) begin
         n_fail++; $display("FAIL bp_duration: got %0d want 205", start_cyc.size() == 1 ? last_wreq_cyc - start_cyc[0] : -1);
      end
      $display("backpressure: %0d bits, 5 stall cycles", obs_q.size());
   endtask

   task automatic test_reject();
      bit ok1, ok2;
      clear_all();
      send_desc(100, 100, 0, 0, 0, ok1);
      wait_idle(1'b0, ok2);
      n_cmp++;
      if (!(ok1 && ok2) || n_err != 1 || n_wreq != 0) begin
         n_fail++; $display("FAIL reject_c0: got err %0d wreq %0d ok %0b%0b want err 1 wreq 0 ok 11", n_err, n_wreq, ok1, ok2);
      end
      send_desc(0, 24, 0, 2, 0, ok1);
      wait_idle(1'b0, ok2);
      n_cmp++;
      if (!(ok1 && ok2) || n_err != 2 || n_wreq != 0 || start_cyc.size() != 0) begin
         n_fail++; $display("FAIL reject_short: got err %0d wreq %0d starts %0d want err 2 wreq 0 starts 0", n_err, n_wreq, start_cyc.size());
      end
      $display("reject: %0d descriptors rejected", n_err);
   endtask

   task automatic test_reset_mid();
      bit ok1, ok2;
      int d, n, w0;
      logic [13:0] vec;
      clear_all();
      send_desc(6144, 0, 1, 0, 0, ok1);
      n = 0;
      while (n_wreq < 100 && n < 300) begin tick(); n++; end
      reset = 1'b1;
      #1;
      vec = {wreq, busy, mux_fill, crc_nshift, data_rd, crc_en, start, desc_rd,
             mux_crc, filling, crc_phase, last_block, desc_err, crc_init};
      n_cmp++;
      if (vec !== 14'b00_11_0000_000000 || block_len !== '0) begin
         n_fail++; $display("FAIL reset_mid_outputs: got %b len %0d want %b len 0", vec, block_len, 14'b00_11_0000_000000);
      end
      w0 = n_wreq;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      n_cmp++;
      if (n_wreq != w0 || w0 != 100) begin
         n_fail++; $display("FAIL reset_mid_stop: got %0d wreq want 100", n_wreq);
      end
      clear_all();
      model_job(0, 64, 0, 1, 3);
      send_desc(0, 64, 0, 1, 3, ok1);
      wait_idle(1'b0, ok2);
      d = q_diff(obs_q, exp_q);
      n_cmp++;
      if (d != -1 || !(ok1 && ok2)) begin
         n_fail++; $display("FAIL reset_mid_next_job: got %0d bits want %0d (diff idx %0d)", obs_q.size(), exp_q.size(), d);
      end
      $display("reset_mid: abandoned after 100 bits, next job %0d bits", obs_q.size());
   endtask

   task automatic test_random();
      bit ok1, ok2, all_ok;
      int d, kp, km, cp, cm, f;
      clear_all();
      all_ok = 1'b1;
      for (int j = 0; j < 10; j++) begin
         kp = $urandom_range(1, 150); km = $urandom_range(1, 150);
         cp = $urandom_range(0, 3);   cm = $urandom_range(0, 3);
         f  = $urandom_range(0, 30);
         model_job(kp, km, cp, cm, f);
         send_desc(kp, km, cp, cm, f, ok1);
         wait_idle(1'b1, ok2);
         all_ok = all_ok && ok1 && ok2;
         $display("random job %0d: K+=%0d K-=%0d C+=%0d C-=%0d F=%0d", j, kp, km, cp, cm, f);
      end
      n_cmp++;
      if (!all_ok) begin n_fail++; $display("FAIL random_timeout: got ok=0 want 1"); end
      d = q_diff(obs_q, exp_q);
      n_cmp++;
      if (d != -1) begin n_fail++; $display("FAIL random_bits: got %0d bits want %0d (diff idx %0d)", obs_q.size(), exp_q.size(), d); end
      n_cmp++;
      if (q_diff(start_len, exp_len) != -1 || q_diff(start_last, exp_last) != -1 || n_start_bad != 0) begin
         n_fail++; $display("FAIL random_blocks: got %0d starts (%0d bad) want %0d", start_len.size(), n_start_bad, exp_len.size());
      end
      n_cmp++;
      if (n_rd != exp_rd || n_bad_rd != 0 || n_stray != 0) begin
         n_fail++; $display("FAIL random_reads: got %0d reads %0d bad %0d stray want %0d 0 0", n_rd, n_bad_rd, n_stray, exp_rd);
      end
      n_cmp++;
      if (n_err != exp_err) begin n_fail++; $display("FAIL random_desc_err: got %0d want %0d", n_err, exp_err); end
   endtask

   initial begin
      clear_all();
      test_reset();
      test_single_block();
      test_two_blocks_crc();
      test_mixed();
      test_backpressure();
      test_reject();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
